// File: rtl/hazard_ctrl.sv
// Hazard and control unit for the five-stage LC-3b pipeline.
// Produces EX operand-forwarding selects and the load/clear strobes for every
// pipeline register. It tracks data-memory waits, branch redirects that must
// wait for an outstanding instruction fetch, and stall/flush counts.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       src1_EX,
  input  logic [2:0]       src2_EX,
  input  logic             use1_EX,
  input  logic             use2_EX,
  input  logic [2:0]       dest_EX,
  input  logic             regwr_EX,
  input  logic             load_EX,
  input  logic [2:0]       src1_ID,
  input  logic [2:0]       src2_ID,
  input  logic             use1_ID,
  input  logic             use2_ID,
  input  logic [2:0]       dest_MEM,
  input  logic             regwr_MEM,
  input  logic [2:0]       dest_WB,
  input  logic             regwr_WB,
  input  logic             br_valid_EX,
  input  logic             br_taken_EX,
  input  logic             prediction_EX,
  input  logic             imem_resp,
  input  logic             dmem_req_MEM,
  input  logic             dmem_resp,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             redirect,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             id_ex_load,
  output logic             ex_mem_load,
  output logic             mem_wb_load,
  output logic             if_id_clear,
  output logic             id_ex_clear,
  output logic             ex_mem_clear,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {RUN, DWAIT} state_t;

  state_t state, state_nxt;
  logic   redirect_pending, pending_nxt;
  logic   load_use, mispredict, data_stall;

  // Newest producer wins: EX/MEM is checked before MEM/WB. R0 is not special.
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [2:0] src,
                                         input logic wr_mem, input logic [2:0] d_mem,
                                         input logic wr_wb, input logic [2:0] d_wb);
    if (use_src && wr_mem && (d_mem == src))   return 2'b01;
    else if (use_src && wr_wb && (d_wb == src)) return 2'b10;
    else                                        return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Hazard detection; a frozen pipe keeps EX intact so these re-evaluate after release.
  always_comb begin
    load_use   = load_EX && regwr_EX &&
                 ((use1_ID && (src1_ID == dest_EX)) || (use2_ID && (src2_ID == dest_EX)));
    mispredict = br_valid_EX && (br_taken_EX != prediction_EX);
    data_stall = ((state == RUN) && dmem_req_MEM && !dmem_resp) ||
                 ((state == DWAIT) && !dmem_resp);
  end

  // Next-state logic for the data-memory FSM and the pending-redirect flag.
  always_comb begin
    state_nxt   = state;
    pending_nxt = redirect_pending;
    case (state)
      RUN:     if (dmem_req_MEM && !dmem_resp) state_nxt = DWAIT;
      DWAIT:   if (dmem_resp)                  state_nxt = RUN;
      default:                                 state_nxt = RUN;
    endcase
    if (!data_stall) begin
      if (mispredict)                        pending_nxt = !imem_resp;
      else if (redirect_pending && imem_resp) pending_nxt = 1'b0;
    end
  end

  // Forwarding selects and pipeline strobes, in hazard priority order.
  always_comb begin
    fwd_a_sel    = fwd_sel(use1_EX, src1_EX, regwr_MEM, dest_MEM, regwr_WB, dest_WB);
    fwd_b_sel    = fwd_sel(use2_EX, src2_EX, regwr_MEM, dest_MEM, regwr_WB, dest_WB);
    redirect     = 1'b0;
    pc_load      = 1'b1;
    if_id_load   = 1'b1;
    id_ex_load   = 1'b1;
    ex_mem_load  = 1'b1;
    mem_wb_load  = 1'b1;
    if_id_clear  = 1'b0;
    id_ex_clear  = 1'b0;
    ex_mem_clear = 1'b0;
    if (!rst_n) begin
      fwd_a_sel    = 2'b00;
      fwd_b_sel    = 2'b00;
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_load   = 1'b0;
      ex_mem_load  = 1'b0;
      mem_wb_load  = 1'b0;
      if_id_clear  = 1'b1;
      id_ex_clear  = 1'b1;
      ex_mem_clear = 1'b1;
    end else if (data_stall) begin
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      id_ex_load  = 1'b0;
      ex_mem_load = 1'b0;
      mem_wb_load = 1'b0;
    end else if (mispredict) begin
      redirect    = 1'b1;
      if_id_clear = 1'b1;
      id_ex_clear = 1'b1;
      pc_load     = imem_resp;
    end else if (redirect_pending) begin
      // Discard the stale fetch once it lands, then steer the PC to the target.
      if (imem_resp) begin
        redirect    = 1'b1;
        if_id_clear = 1'b1;
        id_ex_clear = 1'b1;
      end else begin
        pc_load     = 1'b0;
        if_id_load  = 1'b0;
        id_ex_clear = 1'b1;
      end
    end else if (load_use || !imem_resp) begin
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      id_ex_clear = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= RUN;
      redirect_pending <= 1'b0;
    end else begin
      state            <= state_nxt;
      redirect_pending <= pending_nxt;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_load || !if_id_load) stall_cnt <= sat_inc(stall_cnt);
      if (redirect)                flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed cycle-by-cycle vectors with a
// queue-based scoreboard checked by an independent monitor.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       src1_EX, src2_EX, dest_EX, src1_ID, src2_ID, dest_MEM, dest_WB;
  logic             use1_EX, use2_EX, regwr_EX, load_EX, use1_ID, use2_ID;
  logic             regwr_MEM, regwr_WB, br_valid_EX, br_taken_EX, prediction_EX;
  logic             imem_resp, dmem_req_MEM, dmem_resp;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             redirect, pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic             if_id_clear, id_ex_clear, ex_mem_clear;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .src1_EX(src1_EX), .src2_EX(src2_EX), .use1_EX(use1_EX), .use2_EX(use2_EX),
    .dest_EX(dest_EX), .regwr_EX(regwr_EX), .load_EX(load_EX),
    .src1_ID(src1_ID), .src2_ID(src2_ID), .use1_ID(use1_ID), .use2_ID(use2_ID),
    .dest_MEM(dest_MEM), .regwr_MEM(regwr_MEM), .dest_WB(dest_WB), .regwr_WB(regwr_WB),
    .br_valid_EX(br_valid_EX), .br_taken_EX(br_taken_EX), .prediction_EX(prediction_EX),
    .imem_resp(imem_resp), .dmem_req_MEM(dmem_req_MEM), .dmem_resp(dmem_resp),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .redirect(redirect),
    .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
    .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
    .if_id_clear(if_id_clear), .id_ex_clear(id_ex_clear), .ex_mem_clear(ex_mem_clear),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [12:0] o;
    logic [3:0]  sc;
    logic [3:0]  fc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // {fa, fb, redirect, {pc,if_id,id_ex,ex_mem,mem_wb}_load, {if_id,id_ex,ex_mem}_clear}
  function automatic logic [12:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic red, input logic [4:0] ld, input logic [2:0] cl);
    return {fa, fb, red, ld, cl};
  endfunction

  logic [12:0] NORM, FRZ, RST, LU, MP, MPW;

  // Monitor: outputs are combinational, so every cycle presents a response.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [12:0] act;
      e   = q.pop_front();
      act = {fwd_a_sel, fwd_b_sel, redirect,
             pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
             if_id_clear, id_ex_clear, ex_mem_clear};
      n_tests++;
      if (act !== e.o || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
        n_fail++;
        $display("FAIL %s: got out=%b stall=%0d flush=%0d, expected out=%b stall=%0d flush=%0d",
                 e.name, act, stall_cnt, flush_cnt, e.o, e.sc, e.fc);
      end
    end
  end

  task automatic defaults();
    src1_EX = 0; src2_EX = 0; use1_EX = 0; use2_EX = 0;
    dest_EX = 0; regwr_EX = 0; load_EX = 0;
    src1_ID = 0; src2_ID = 0; use1_ID = 0; use2_ID = 0;
    dest_MEM = 0; regwr_MEM = 0; dest_WB = 0; regwr_WB = 0;
    br_valid_EX = 0; br_taken_EX = 0; prediction_EX = 0;
    imem_resp = 1; dmem_req_MEM = 0; dmem_resp = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    defaults();
  endtask

  task automatic expect_out(input string nm, input logic [12:0] o, input int sc, input int fc);
    exp_t e;
    e.name = nm; e.o = o; e.sc = sc[3:0]; e.fc = fc[3:0];
    q.push_back(e);
  endtask

  task automatic mispredict_in(input logic imem);
    br_valid_EX = 1; br_taken_EX = 1; prediction_EX = 0; imem_resp = imem;
  endtask

  initial begin
    NORM = mk(2'b00, 2'b00, 1'b0, 5'b11111, 3'b000);
    FRZ  = mk(2'b00, 2'b00, 1'b0, 5'b00000, 3'b000);
    RST  = mk(2'b00, 2'b00, 1'b0, 5'b00000, 3'b111);
    LU   = mk(2'b00, 2'b00, 1'b0, 5'b00111, 3'b010);
    MP   = mk(2'b00, 2'b00, 1'b1, 5'b11111, 3'b110);
    MPW  = mk(2'b00, 2'b00, 1'b1, 5'b01111, 3'b110);
    rst_n = 0;
    defaults();

    // Reset forces outputs even with a forwarding match present
    next_cycle();
    src1_EX = 1; use1_EX = 1; regwr_MEM = 1; dest_MEM = 1;
    expect_out("reset_outputs", RST, 0, 0);

    // Forwarding
    next_cycle(); rst_n = 1;
    src1_EX = 1; src2_EX = 1; use1_EX = 1; use2_EX = 1; regwr_MEM = 1; dest_MEM = 1;
    expect_out("fwd_mem", mk(2'b01, 2'b01, 1'b0, 5'b11111, 3'b000), 0, 0);
    next_cycle();
    src1_EX = 1; src2_EX = 1; use1_EX = 1; use2_EX = 1; regwr_WB = 1; dest_WB = 1;
    expect_out("fwd_wb", mk(2'b10, 2'b10, 1'b0, 5'b11111, 3'b000), 0, 0);
    next_cycle();
    src1_EX = 1; src2_EX = 1; use1_EX = 1; use2_EX = 1;
    regwr_MEM = 1; dest_MEM = 1; regwr_WB = 1; dest_WB = 1;
    expect_out("fwd_mem_priority", mk(2'b01, 2'b01, 1'b0, 5'b11111, 3'b000), 0, 0);
    next_cycle();
    src1_EX = 2; src2_EX = 5; use1_EX = 1; use2_EX = 1;
    regwr_MEM = 1; dest_MEM = 5; regwr_WB = 1; dest_WB = 2;
    expect_out("fwd_mixed", mk(2'b10, 2'b01, 1'b0, 5'b11111, 3'b000), 0, 0);
    next_cycle();
    src1_EX = 3; use1_EX = 0; src2_EX = 0; use2_EX = 1;
    regwr_MEM = 1; dest_MEM = 3; regwr_WB = 1; dest_WB = 0;
    expect_out("fwd_nouse_r0", mk(2'b00, 2'b10, 1'b0, 5'b11111, 3'b000), 0, 0);
    next_cycle();
    src1_EX = 4; use1_EX = 1; regwr_MEM = 0; dest_MEM = 4;
    expect_out("fwd_nowrite", NORM, 0, 0);

    // Load-use: one bubble, then forward from WB
    next_cycle();
    load_EX = 1; regwr_EX = 1; dest_EX = 3; use2_ID = 1; src2_ID = 3;
    expect_out("loaduse_bubble", LU, 0, 0);
    next_cycle();
    src1_EX = 3; use1_EX = 1; regwr_WB = 1; dest_WB = 3;
    expect_out("loaduse_after", mk(2'b10, 2'b00, 1'b0, 5'b11111, 3'b000), 1, 0);
    next_cycle();
    load_EX = 1; regwr_EX = 1; dest_EX = 3; src1_ID = 3; use1_ID = 0; use2_ID = 1; src2_ID = 4;
    expect_out("loaduse_nomatch", NORM, 1, 0);
    next_cycle();
    load_EX = 0; regwr_EX = 1; dest_EX = 3; src1_ID = 3; use1_ID = 1;
    expect_out("loaduse_notload", NORM, 1, 0);

    // Mispredict with fetch ready; correct prediction does nothing
    next_cycle(); mispredict_in(1'b1);
    expect_out("mispredict", MP, 1, 0);
    next_cycle(); br_valid_EX = 1; br_taken_EX = 1; prediction_EX = 1;
    expect_out("br_correct", NORM, 1, 1);

    // Data stall: 4 cycles without response, mispredict held during the stall
    next_cycle(); dmem_req_MEM = 1;
    expect_out("dstall_0", FRZ, 1, 1);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); dmem_req_MEM = 1; mispredict_in(1'b1);
      load_EX = 1; regwr_EX = 1; dest_EX = 2; use1_ID = 1; src1_ID = 2;
      expect_out("dstall_wait", FRZ, 2 + i, 1);
    end
    next_cycle(); dmem_req_MEM = 1; dmem_resp = 1; mispredict_in(1'b1);
    expect_out("dstall_release_redirect", MP, 5, 1);
    next_cycle();
    expect_out("dstall_back_run", NORM, 5, 2);
    next_cycle(); dmem_req_MEM = 1; dmem_resp = 1;
    expect_out("dmem_single_cycle", NORM, 5, 2);
    next_cycle();
    expect_out("dmem_single_stays_run", NORM, 5, 2);

    // Mispredict while fetch outstanding for 3 cycles
    next_cycle(); mispredict_in(1'b0);
    expect_out("mispredict_nofetch", MPW, 5, 2);
    next_cycle(); imem_resp = 0;
    expect_out("pending_wait1", LU, 6, 3);
    next_cycle(); imem_resp = 0;
    expect_out("pending_wait2", LU, 7, 3);
    next_cycle();
    expect_out("pending_resp", MP, 8, 3);
    next_cycle();
    expect_out("pending_cleared", NORM, 8, 4);

    // Fetch stall
    next_cycle(); imem_resp = 0;
    expect_out("fetch_stall", LU, 8, 4);

    // Long data stall drives stall_cnt into saturation
    for (int i = 0; i < 9; i++) begin
      next_cycle(); dmem_req_MEM = 1;
      expect_out("stall_saturate", FRZ, (9 + i > 15) ? 15 : 9 + i, 4);
    end

    // Asynchronous reset in the middle of DWAIT
    next_cycle(); dmem_req_MEM = 1; rst_n = 0;
    expect_out("reset_mid_dwait", RST, 0, 0);
    next_cycle(); dmem_req_MEM = 1;
    expect_out("reset_held", RST, 0, 0);
    next_cycle(); rst_n = 1;
    expect_out("after_reset_run", NORM, 0, 0);
    next_cycle();
    expect_out("after_reset_run2", NORM, 0, 0);

    // Reset with a redirect pending must not leave a stale redirect
    next_cycle(); mispredict_in(1'b0);
    expect_out("mispredict_before_reset", MPW, 0, 0);
    next_cycle(); rst_n = 0;
    expect_out("reset_pending", RST, 0, 0);
    next_cycle(); rst_n = 1;
    expect_out("no_stale_redirect", NORM, 0, 0);
    next_cycle();
    expect_out("idle_final", NORM, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
